if_id_pipe_reg: RTL and testbench
=================================

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter PC_W, default 9, program-counter width in bits.
REQ-003 The block SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction (ADDI x0,x0,0), used only under REQ-031.
REQ-004 clk  input  1  single clock; all state SHALL update on the falling edge of clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream (IF) presents a fetched instruction.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 inst_in  input  DATA_W  fetched instruction.
REQ-009 ipc  input  PC_W  PC of inst_in.
REQ-010 Pause  input  1  hazard-unit stall; blocks dequeue only.
REQ-011 Flush  input  1  branch/jump squash; discards all held entries.
REQ-012 out_valid  output  1  head entry valid for ID.
REQ-013 out_ready  input  1  ID consumes head entry.
REQ-014 inst_out  output  DATA_W  head instruction.
REQ-015 opc  output  PC_W  head PC.

Function
REQ-016 Storage SHALL be a 2-entry in-order buffer (head + skid), each entry holding {inst, pc}; occupancy states EMPTY, ONE, FULL.
REQ-017 push SHALL be in_valid && in_ready; pop SHALL be out_valid && out_ready && !Pause.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL be a function of occupancy only (no combinational path from out_ready or Pause).
REQ-019 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-020 Latency: an entry pushed at falling edge N SHALL appear on inst_out/opc with out_valid=1 immediately after edge N when the buffer was EMPTY or popped at edge N.
REQ-021 Transitions: EMPTY-push->ONE; ONE-push&!pop->FULL; ONE-pop&!push->EMPTY; ONE-push&pop->ONE (new entry becomes head); FULL-pop->ONE (skid becomes head); no other event changes state.
REQ-022 Order SHALL be preserved: entries leave in push order, none duplicated or lost absent Flush/rst.
REQ-023 Pause=1 SHALL hold head, skid and occupancy unchanged except that a push into EMPTY or ONE still completes.
REQ-024 Flush=1 at an edge SHALL set occupancy EMPTY and zero both entries; a same-edge push and pop SHALL be discarded; Flush SHALL override Pause.
REQ-025 Without REQ-031, inst_out/opc SHALL reflect head-entry contents regardless of out_valid (zero after reset/Flush).
REQ-026 ipc SHALL be stored zero-extended-free at exactly PC_W bits; inst_in at exactly DATA_W bits; no truncation or padding.

Reset
REQ-027 rst=1 at a falling edge SHALL set occupancy EMPTY and both entries to zero, overriding push, pop, Pause and Flush.
REQ-028 After reset: out_valid=0, in_ready=1, inst_out=0 (NOP_INST under REQ-031), opc=0.
REQ-029 Reset asserted mid-operation SHALL discard any held entries; no entry SHALL emerge after reset deasserts unless pushed afterwards.

Configuration
REQ-030 Macro IFID_BUBBLE_NOP_EN SHALL select bubble insertion.
REQ-031 With IFID_BUBBLE_NOP_EN defined, inst_out SHALL equal NOP_INST and opc SHALL equal 0 whenever out_valid=0; without it, REQ-025 applies; state and handshake behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset then push inst 0x00A00093 pc 0x004, out_ready=1 -> next edge out_valid=1, inst_out=0x00A00093, opc=0x004; following edge EMPTY.
REQ-033 out_ready=0, push 0x111,0x222,0x333 on consecutive edges -> after 2nd push in_ready=0, 3rd not accepted; then out_ready=1 -> 0x111, 0x222 emerge in order, in_ready returns 1 after first pop.
REQ-034 FULL with Pause=1, out_ready=1 for 3 edges -> head/skid/outputs unchanged; Pause=0 -> pops resume in order.
REQ-035 FULL, Flush=1 with in_valid=1 same edge -> next edge out_valid=0, in_ready=1, inst_out=0 (NOP_INST=0x00000013 with macro), pushed word never appears.
REQ-036 ONE with simultaneous push 0xBEEF and pop -> occupancy stays ONE, inst_out=0xBEEF next edge.
REQ-037 rst=1 while FULL with Flush=0, Pause=1 -> next edge out_valid=0, opc=0, in_ready=1.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: 2-entry in-order skid buffer with a valid/ready handshake, a hazard stall and a squash.
// Optional build macro IFID_BUBBLE_NOP_EN drives NOP_INST with opc 0 onto the ID side whenever out_valid is 0.
module if_id_pipe_reg #(
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 9,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [PC_W-1:0]   ipc,
    input  logic              Pause,
    input  logic              Flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [PC_W-1:0]   opc
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } occ_t;

    occ_t              state_r, state_s;
    logic [DATA_W-1:0] head_inst_r, head_inst_s;
    logic [PC_W-1:0]   head_pc_r, head_pc_s;
    logic [DATA_W-1:0] skid_inst_r, skid_inst_s;
    logic [PC_W-1:0]   skid_pc_r, skid_pc_s;
    logic              push_s;
    logic              pop_s;

    // Handshake flags depend on occupancy only, so ready never depends combinationally on out_ready or Pause.
    always_comb begin
        in_ready  = (state_r != FULL);
        out_valid = (state_r != EMPTY);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready && !Pause;
    end

    // Next occupancy and entry contents; Flush empties and clears both entries, and it overrides Pause.
    always_comb begin
        state_s     = state_r;
        head_inst_s = head_inst_r;
        head_pc_s   = head_pc_r;
        skid_inst_s = skid_inst_r;
        skid_pc_s   = skid_pc_r;
        if (Flush) begin
            state_s     = EMPTY;
            head_inst_s = {DATA_W{1'b0}};
            head_pc_s   = {PC_W{1'b0}};
            skid_inst_s = {DATA_W{1'b0}};
            skid_pc_s   = {PC_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        state_s     = ONE;
                        head_inst_s = inst_in;
                        head_pc_s   = ipc;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        head_inst_s = inst_in;
                        head_pc_s   = ipc;
                    end else if (push_s) begin
                        state_s     = FULL;
                        skid_inst_s = inst_in;
                        skid_pc_s   = ipc;
                    end else if (pop_s) begin
                        state_s = EMPTY;
                    end else begin
                        state_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low in FULL, so a pop is the only possible event here.
                    if (pop_s) begin
                        state_s     = ONE;
                        head_inst_s = skid_inst_r;
                        head_pc_s   = skid_pc_r;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s     = EMPTY;
                    head_inst_s = {DATA_W{1'b0}};
                    head_pc_s   = {PC_W{1'b0}};
                    skid_inst_s = {DATA_W{1'b0}};
                    skid_pc_s   = {PC_W{1'b0}};
                end
            endcase
        end
    end

    // State register on the falling edge; rst overrides every other input.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            head_inst_r <= {DATA_W{1'b0}};
            head_pc_r   <= {PC_W{1'b0}};
            skid_inst_r <= {DATA_W{1'b0}};
            skid_pc_r   <= {PC_W{1'b0}};
        end else begin
            state_r     <= state_s;
            head_inst_r <= head_inst_s;
            head_pc_r   <= head_pc_s;
            skid_inst_r <= skid_inst_s;
            skid_pc_r   <= skid_pc_s;
        end
    end

    // Output side: head entry, or a bubble while the buffer is empty.
`ifdef IFID_BUBBLE_NOP_EN
    always_comb begin
        if (out_valid) begin
            inst_out = head_inst_r;
            opc      = head_pc_r;
        end else begin
            inst_out = NOP_INST;
            opc      = {PC_W{1'b0}};
        end
    end
`else
    always_comb begin
        inst_out = head_inst_r;
        opc      = head_pc_r;
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg. State updates on the falling edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_if_id_pipe_reg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 9;
`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [DATA_W-1:0] IDLE_INST = 32'h00000013;
`else
    localparam logic [DATA_W-1:0] IDLE_INST = 32'h00000000;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] inst_in = 32'h0;
    logic [PC_W-1:0]   ipc = 9'h0;
    logic              Pause = 1'b0;
    logic              Flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] inst_out;
    logic [PC_W-1:0]   opc;

    int checks = 0;
    int errors = 0;

    if_id_pipe_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_in(inst_in), .ipc(ipc), .Pause(Pause), .Flush(Flush),
        .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out), .opc(opc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One falling (active) edge, then settle just past the next rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p);
        in_valid = v;
        inst_in  = d;
        ipc      = p;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic r,
                              input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p);
        check_val({tag, "_valid"}, 64'(out_valid), 64'(v));
        check_val({tag, "_ready"}, 64'(in_ready), 64'(r));
        check_val({tag, "_inst"}, 64'(inst_out), 64'(d));
        check_val({tag, "_pc"}, 64'(opc), 64'(p));
    endtask

    initial begin
        // Reset state
        tick();
        rst = 1'b0;
        expect_out("reset", 1'b0, 1'b1, IDLE_INST, 9'h000);

        // Single push with immediate visibility, then drain
        drive(1'b1, 32'h00A00093, 9'h004);
        out_ready = 1'b1;
        tick();
        expect_out("single", 1'b1, 1'b1, 32'h00A00093, 9'h004);
        drive(1'b0, 32'h0, 9'h0);
        tick();
        check_val("single_drain_valid", 64'(out_valid), 64'h0);
        check_val("single_drain_ready", 64'(in_ready), 64'h1);

        // Fill to FULL, third push refused, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h111, 9'h001);
        tick();
        expect_out("fill1", 1'b1, 1'b1, 32'h111, 9'h001);
        drive(1'b1, 32'h222, 9'h002);
        tick();
        expect_out("fill2", 1'b1, 1'b0, 32'h111, 9'h001);
        drive(1'b1, 32'h333, 9'h003);
        tick();
        expect_out("fill3_refused", 1'b1, 1'b0, 32'h111, 9'h001);
        drive(1'b0, 32'h0, 9'h0);
        out_ready = 1'b1;
        tick();
        expect_out("pop1", 1'b1, 1'b1, 32'h222, 9'h002);
        tick();
        check_val("pop2_empty", 64'(out_valid), 64'h0);

        // FULL held under Pause for three edges, then resumes in order
        out_ready = 1'b0;
        drive(1'b1, 32'hAAA, 9'h010);
        tick();
        drive(1'b1, 32'hBBB, 9'h011);
        tick();
        drive(1'b0, 32'h0, 9'h0);
        Pause = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("pause_hold", 1'b1, 1'b0, 32'hAAA, 9'h010);
        end
        Pause = 1'b0;
        tick();
        expect_out("pause_resume", 1'b1, 1'b1, 32'hBBB, 9'h011);
        tick();
        check_val("pause_resume_empty", 64'(out_valid), 64'h0);

        // Pushes still complete while paused
        Pause = 1'b1;
        drive(1'b1, 32'hCCC, 9'h012);
        tick();
        expect_out("pause_push1", 1'b1, 1'b1, 32'hCCC, 9'h012);
        drive(1'b1, 32'hDDD, 9'h013);
        tick();
        expect_out("pause_push2", 1'b1, 1'b0, 32'hCCC, 9'h012);

        // Flush from FULL with Pause and an offered push: everything discarded
        Flush = 1'b1;
        drive(1'b1, 32'hEEE, 9'h014);
        tick();
        expect_out("flush", 1'b0, 1'b1, IDLE_INST, 9'h000);
        Flush = 1'b0;
        Pause = 1'b0;
        drive(1'b0, 32'h0, 9'h0);
        tick();
        expect_out("flush_after", 1'b0, 1'b1, IDLE_INST, 9'h000);

        // Simultaneous push and pop in ONE: new word becomes head
        out_ready = 1'b0;
        drive(1'b1, 32'h123, 9'h020);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000BEEF, 9'h021);
        tick();
        expect_out("pushpop", 1'b1, 1'b1, 32'h0000BEEF, 9'h021);
        // Full-width instruction and maximum PC survive without truncation
        drive(1'b1, 32'hFFFFFFFF, 9'h1FF);
        tick();
        expect_out("wide", 1'b1, 1'b1, 32'hFFFFFFFF, 9'h1FF);
        drive(1'b0, 32'h0, 9'h0);
        tick();
        check_val("wide_drain", 64'(out_valid), 64'h0);

        // Reset while FULL and paused discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'h5, 9'h005);
        tick();
        drive(1'b1, 32'h6, 9'h006);
        tick();
        check_val("prereset_full", 64'(in_ready), 64'h0);
        drive(1'b0, 32'h0, 9'h0);
        rst = 1'b1;
        Pause = 1'b1;
        out_ready = 1'b1;
        tick();
        expect_out("rst_full", 1'b0, 1'b1, IDLE_INST, 9'h000);
        rst = 1'b0;
        Pause = 1'b0;
        tick();
        expect_out("rst_after", 1'b0, 1'b1, IDLE_INST, 9'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
